car_drivetrain: RTL and testbench
=================================

# car_drivetrain

Per-player drivetrain model for the drag race: turns held-throttle and gear-shift key events into engine RPM, gear, speed and track position. One instance per player sits between the keyboard interface and the renderers. Its `position` feeds the background scroll and car sprite, its `rpm`/`gear` feed the tachometer overlay, and its `finished` flag feeds the timers and scoreboard. All arithmetic advances only on a slow `step` strobe, so the block runs on the pixel clock.

## Interface
Parameters:
- `FINISH_LINE_POS`, default 1200: position, in pixels, at which the car is finished.
- `RPM_IDLE`, default 1000: floor RPM and reset RPM.
- `RPM_MAX`, default 8000: redline.

Ports:
- `clk`  in  1  system clock (65 MHz pixel clock).
- `rst_n`  in  1  reset, asynchronous and active-low. This is the one clock and async active-low reset decided for this block.
- `step`  in  1  one-`clk` update strobe (≈65 Hz).
- `restart`  in  1  one-`clk` pulse that returns the block to the reset state.
- `launch`  in  1  level; 1 means the lights are out and the car may move.
- `throttle`  in  1  level; throttle key held.
- `shift_up`  in  1  one-`clk` pulse.
- `shift_down`  in  1  one-`clk` pulse.
- `rpm`  out  14  engine RPM.
- `gear`  out  3  gear, 1..5.
- `speed`  out  14  speed in 1/256 px per step.
- `position`  out  32  pixels travelled, integer part.
- `limiter`  out  1  rev limiter fired on the last step.
- `finished`  out  1  finish line reached.

## Operation
- States:
  - STAGED: `launch`=0. RPM updates; position is frozen at 0.
  - RUNNING: entered on the first step with `launch`=1.
  - FINISHED: entered when `position` ≥ `FINISH_LINE_POS`.
- In FINISHED, `position`, `speed`, `gear` and `rpm` all hold, and `finished`=1.
- Shift pulses are latched into `up_pend` and `down_pend` on any `clk` cycle and consumed on the next `step`.
  - If both are pending at that step, both are cleared and no shift occurs.
  - Repeated pulses before a step collapse into one request.
- Update on a `step` cycle, in this order:
  1. Shift.
     - Up: if gear<5, then gear+1 and rpm = max(rpm−DROP[g_old], RPM_IDLE). At gear 5 the request is ignored.
     - Down: if gear>1 and rpm+DROP[g_new] ≤ `RPM_MAX`, then gear−1 and rpm += DROP[g_new]. Otherwise the request is rejected.
  2. RPM.
     - If `limiter` was 1: rpm −= LIMIT_CUT (500), regardless of throttle.
     - Else if `throttle`: rpm += RISE[gear].
     - Else: rpm −= DECAY (150).
     - Clamp to [RPM_IDLE, RPM_MAX].
     - Reaching `RPM_MAX` through throttle sets `limiter` for exactly one step.
  3. Speed: `speed` = (rpm_new × K[gear_new]) >> 8, with a 22-bit product. Always computed, including in STAGED.
  4. Position: in RUNNING only, {position, frac8} += previous `speed`. The 40-bit sum saturates at all-ones and never wraps.
  5. Finish: compare the new position against `FINISH_LINE_POS` and enter FINISHED in the same step.
- Tables, indexed by gear 1..5:
  - RISE = 400, 300, 220, 160, 120.
  - K = 12, 18, 24, 30, 36.
  - DROP[1..4] = 2500, 2000, 1600, 1300 (upshift out of gear g uses DROP[g]).
- `restart` has priority over `step` and over shift pulses. It clears the pending shift requests.
- `launch` falling while in RUNNING is ignored, so there is no return to STAGED.

## Timing
- Reset (`rst_n`=0, or a `restart` pulse) sets every output and register to:
  - STAGED, rpm=`RPM_IDLE`, gear=1.
  - speed = (1000×12)>>8 = 46.
  - position=0, frac=0, limiter=0, finished=0.
  - Both pending flags = 0.
- `rst_n` clears everything asynchronously. Release is synchronous to `clk` at the top level.
- All outputs are registered. Results of a `step` in cycle N are visible in cycle N+1. No output changes on non-step cycles except through reset or `restart`.
- A shift pulse in the same cycle as `step` is consumed by that step.
- `step` and `restart` in the same cycle: `restart` wins, and the step is lost.

## Structure
- `drag_pkg` holds:
  - Tables RISE, K, DROP.
  - Constants DECAY, LIMIT_CUT.
  - State enum `dt_state_t` {STAGED, RUNNING, FINISHED}.
  - Width constants RPM_W=14 and POS_W=32.
  - `FINISH_LINE_POS` is shared with `draw_background` through this package.
- Sub-module `shift_request_latch` holds the two sticky pending flags. It exposes the clear-on-step behaviour and the both-pending cancel rule.
- Datapath: one 14×6 multiplier and one 40-bit accumulator.

## Test plan
- Idle revving: reset, `throttle`=1, 3 steps, `launch`=0 → rpm 1400, 1800, 2200; speed 103 after step 3; position stays 0.
- Rev limiter: gear 1 at rpm 7800 with throttle, 1 step → rpm 8000, limiter=1. Next step with throttle → rpm 7500, limiter=0.
- Upshift and rejected downshift:
  - rpm 6000, gear 1, `shift_up` then step → gear 2, rpm 6000−2500+300 = 3800.
  - At gear 2, rpm 7000, `shift_down` → rejected (7000+2500 > 8000), so gear stays 2.
- Simultaneous shifts: `shift_up` and `shift_down` pulsed in different cycles before one step → gear unchanged, both pending flags 0 afterwards.
- Finish: `FINISH_LINE_POS`=10, launch with speed held at 768 (3 px/step) → position 3, 6, 9, 12. `finished`=1 after step 4, and position holds at 12 on later steps.
- Restart mid-run: in RUNNING at position 500, pulse `restart` together with `step` → the next cycle shows exactly the reset values. Also assert `rst_n` mid-step → outputs clear immediately, without waiting for a `clk` edge.

Source files
------------

// File: rtl/drag_pkg.sv
// Shared constants, gear tables and state type for the drag-race drivetrain.
package drag_pkg;

  localparam int RPM_W           = 14;
  localparam int POS_W           = 32;
  localparam int FRAC_W          = 8;
  localparam int FINISH_LINE_POS = 1200;
  localparam int DECAY           = 150;
  localparam int LIMIT_CUT       = 500;

  typedef enum logic [1:0] {STAGED, RUNNING, FINISHED} dt_state_t;

  // RPM gained per step with throttle held, by gear
  function automatic logic [RPM_W-1:0] rise_of(input logic [2:0] g);
    case (g)
      3'd1:    return 14'd400;
      3'd2:    return 14'd300;
      3'd3:    return 14'd220;
      3'd4:    return 14'd160;
      3'd5:    return 14'd120;
      default: return 14'd0;
    endcase
  endfunction

  // Speed gain: speed = (rpm * K) >> 8, by gear
  function automatic logic [5:0] k_of(input logic [2:0] g);
    case (g)
      3'd1:    return 6'd12;
      3'd2:    return 6'd18;
      3'd3:    return 6'd24;
      3'd4:    return 6'd30;
      3'd5:    return 6'd36;
      default: return 6'd0;
    endcase
  endfunction

  // RPM drop when shifting up out of gear g (also the rise when shifting down into g)
  function automatic logic [RPM_W-1:0] drop_of(input logic [2:0] g);
    case (g)
      3'd1:    return 14'd2500;
      3'd2:    return 14'd2000;
      3'd3:    return 14'd1600;
      3'd4:    return 14'd1300;
      default: return 14'd0;
    endcase
  endfunction

endpackage

// File: rtl/car_drivetrain_shift_request_latch.sv
// Sticky shift-request flags: set by key pulses, consumed by the next step.
module shift_request_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic step,
  input  logic shift_up,
  input  logic shift_down,
  output logic up_req,
  output logic down_req
);

  logic up_pend_reg;
  logic down_pend_reg;
  logic up_any;
  logic down_any;

  // A pulse arriving on the step cycle itself counts; both pending cancels out
  always_comb begin
    up_any   = up_pend_reg | shift_up;
    down_any = down_pend_reg | shift_down;
    up_req   = step & up_any & ~down_any;
    down_req = step & down_any & ~up_any;
  end

  // Latch pulses until the next step (or restart) clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_pend_reg   <= 1'b0;
      down_pend_reg <= 1'b0;
    end else if (restart || step) begin
      up_pend_reg   <= 1'b0;
      down_pend_reg <= 1'b0;
    end else begin
      if (shift_up)   up_pend_reg   <= 1'b1;
      if (shift_down) down_pend_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/car_drivetrain.sv
// Per-player drivetrain: throttle and shift keys -> rpm, gear, speed, position.
module car_drivetrain
  import drag_pkg::*;
#(
  parameter int FINISH_LINE_POS = drag_pkg::FINISH_LINE_POS,
  parameter int RPM_IDLE        = 1000,
  parameter int RPM_MAX         = 8000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             restart,
  input  logic             launch,
  input  logic             throttle,
  input  logic             shift_up,
  input  logic             shift_down,
  output logic [RPM_W-1:0] rpm,
  output logic [2:0]       gear,
  output logic [RPM_W-1:0] speed,
  output logic [POS_W-1:0] position,
  output logic             limiter,
  output logic             finished
);

  localparam int ACC_W = POS_W + FRAC_W;
  localparam logic [15:0] IDLE_W  = 16'(RPM_IDLE);
  localparam logic [15:0] MAX_W   = 16'(RPM_MAX);
  localparam logic [15:0] CUT_W   = 16'(LIMIT_CUT);
  localparam logic [15:0] DECAY_W = 16'(DECAY);
  localparam logic [POS_W-1:0] FINISH_W  = POS_W'(FINISH_LINE_POS);
  localparam logic [RPM_W-1:0] RPM_RST   = RPM_W'(RPM_IDLE);
  localparam logic [RPM_W-1:0] SPEED_RST = RPM_W'((RPM_IDLE * int'(k_of(3'd1))) >> 8);

  dt_state_t        state_reg;
  logic [RPM_W-1:0] rpm_reg;
  logic [2:0]       gear_reg;
  logic [RPM_W-1:0] speed_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             limiter_reg;
  logic             finished_reg;

  logic             up_req;
  logic             down_req;
  logic [15:0]      rpm_w;
  logic [15:0]      drop_up;
  logic [15:0]      drop_dn;
  logic [2:0]       gear_next;
  logic [15:0]      rpm_shift;
  logic [15:0]      rpm_sum;
  logic [15:0]      rpm_t;
  logic             limiter_next;
  logic [21:0]      product;
  logic [RPM_W-1:0] speed_next;
  logic             moving;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;
  dt_state_t        state_next;

  shift_request_latch u_shift_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .step       (step),
    .shift_up   (shift_up),
    .shift_down (shift_down),
    .up_req     (up_req),
    .down_req   (down_req)
  );

  // Next-step values: shift, then rpm, then speed, then position and finish
  always_comb begin
    rpm_w     = {2'b00, rpm_reg};
    drop_up   = {2'b00, drop_of(gear_reg)};
    drop_dn   = {2'b00, drop_of(gear_reg - 3'd1)};
    gear_next = gear_reg;
    rpm_shift = rpm_w;
    if (up_req && gear_reg < 3'd5) begin
      gear_next = gear_reg + 3'd1;
      rpm_shift = (rpm_w >= drop_up + IDLE_W) ? rpm_w - drop_up : IDLE_W;
    end else if (down_req && gear_reg > 3'd1 && (rpm_w + drop_dn) <= MAX_W) begin
      gear_next = gear_reg - 3'd1;
      rpm_shift = rpm_w + drop_dn;
    end

    rpm_sum      = rpm_shift + {2'b00, rise_of(gear_next)};
    limiter_next = 1'b0;
    if (limiter_reg) begin
      rpm_t = (rpm_shift >= IDLE_W + CUT_W) ? rpm_shift - CUT_W : IDLE_W;
    end else if (throttle) begin
      if (rpm_sum >= MAX_W) begin
        rpm_t        = MAX_W;
        limiter_next = 1'b1;
      end else begin
        rpm_t = rpm_sum;
      end
    end else begin
      rpm_t = (rpm_shift >= IDLE_W + DECAY_W) ? rpm_shift - DECAY_W : IDLE_W;
    end

    product    = 22'(rpm_t[RPM_W-1:0]) * 22'(k_of(gear_next));
    speed_next = product[21:8];

    // The launch step itself already moves the car by the previous speed
    moving   = (state_reg == RUNNING) || (state_reg == STAGED && launch);
    acc_sum  = {1'b0, acc_reg} + (ACC_W + 1)'(speed_reg);
    acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    if (!moving) acc_next = acc_reg;

    state_next = state_reg;
    if (moving) state_next = (acc_next[ACC_W-1:FRAC_W] >= FINISH_W) ? FINISHED : RUNNING;
  end

  // Race FSM and registered datapath; restart beats step, finished freezes the car
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= STAGED;
      rpm_reg      <= RPM_RST;
      gear_reg     <= 3'd1;
      speed_reg    <= SPEED_RST;
      acc_reg      <= '0;
      limiter_reg  <= 1'b0;
      finished_reg <= 1'b0;
    end else if (restart) begin
      state_reg    <= STAGED;
      rpm_reg      <= RPM_RST;
      gear_reg     <= 3'd1;
      speed_reg    <= SPEED_RST;
      acc_reg      <= '0;
      limiter_reg  <= 1'b0;
      finished_reg <= 1'b0;
    end else if (step) begin
      if (state_reg == FINISHED) begin
        limiter_reg <= 1'b0;
      end else begin
        state_reg    <= state_next;
        rpm_reg      <= rpm_t[RPM_W-1:0];
        gear_reg     <= gear_next;
        speed_reg    <= speed_next;
        acc_reg      <= acc_next;
        limiter_reg  <= limiter_next;
        finished_reg <= (state_next == FINISHED);
      end
    end
  end

  assign rpm      = rpm_reg;
  assign gear     = gear_reg;
  assign speed    = speed_reg;
  assign position = acc_reg[ACC_W-1:FRAC_W];
  assign limiter  = limiter_reg;
  assign finished = finished_reg;

endmodule

// File: tb/tb_car_drivetrain.sv
// Directed bench for car_drivetrain with a per-cycle reference model.
module tb_car_drivetrain;

  localparam int FIN  = 40;
  localparam int IDLE = 1000;
  localparam int MAXR = 8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic        restart = 1'b0;
  logic        launch = 1'b0;
  logic        throttle = 1'b0;
  logic        shift_up = 1'b0;
  logic        shift_down = 1'b0;
  logic [13:0] rpm;
  logic [2:0]  gear;
  logic [13:0] speed;
  logic [31:0] position;
  logic        limiter;
  logic        finished;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  car_drivetrain #(.FINISH_LINE_POS(FIN), .RPM_IDLE(IDLE), .RPM_MAX(MAXR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .restart    (restart),
    .launch     (launch),
    .throttle   (throttle),
    .shift_up   (shift_up),
    .shift_down (shift_down),
    .rpm        (rpm),
    .gear       (gear),
    .speed      (speed),
    .position   (position),
    .limiter    (limiter),
    .finished   (finished)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic over the game rules
  int     rise_t [1:5] = '{400, 300, 220, 160, 120};
  int     k_t    [1:5] = '{12, 18, 24, 30, 36};
  int     drop_t [1:4] = '{2500, 2000, 1600, 1300};
  int     m_rpm, m_gear, m_speed, m_old_speed;
  longint m_acc;
  bit     m_lim, m_fin, m_run, m_up, m_dn, m_u, m_d;
  longint ACC_MAX = (longint'(1) << 40) - 1;

  task automatic model_reset();
    m_rpm = IDLE; m_gear = 1; m_speed = (IDLE * 12) / 256; m_acc = 0;
    m_lim = 0; m_fin = 0; m_run = 0; m_up = 0; m_dn = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || restart) begin
      model_reset();
    end else if (step) begin
      m_u = m_up | shift_up;
      m_d = m_dn | shift_down;
      m_up = 0; m_dn = 0;
      if (m_fin) begin
        m_lim = 0;
      end else begin
        m_old_speed = m_speed;
        if (m_u && !m_d && m_gear < 5) begin
          m_rpm = (m_rpm - drop_t[m_gear] > IDLE) ? m_rpm - drop_t[m_gear] : IDLE;
          m_gear = m_gear + 1;
        end else if (m_d && !m_u && m_gear > 1 && m_rpm + drop_t[m_gear-1] <= MAXR) begin
          m_gear = m_gear - 1;
          m_rpm  = m_rpm + drop_t[m_gear];
        end
        if (m_lim) begin
          m_rpm = m_rpm - 500; m_lim = 0;
        end else if (throttle) begin
          m_rpm = m_rpm + rise_t[m_gear]; m_lim = (m_rpm >= MAXR);
        end else begin
          m_rpm = m_rpm - 150;
        end
        if (m_rpm < IDLE) m_rpm = IDLE;
        if (m_rpm > MAXR) m_rpm = MAXR;
        m_speed = (m_rpm * k_t[m_gear]) / 256;
        if (m_run || launch) begin
          m_run = 1;
          m_acc = m_acc + m_old_speed;
          if (m_acc > ACC_MAX) m_acc = ACC_MAX;
          if ((m_acc >> 8) >= FIN) m_fin = 1;
        end
      end
    end else begin
      if (shift_up)   m_up = 1;
      if (shift_down) m_dn = 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_rpm", 64'(rpm), 64'(m_rpm));
      check("m_gear", 64'(gear), 64'(m_gear));
      check("m_speed", 64'(speed), 64'(m_speed));
      check("m_position", 64'(position), 64'(m_acc >> 8));
      check("m_limiter", 64'(limiter), 64'(m_lim));
      check("m_finished", 64'(finished), 64'(m_fin));
    end
  end

  // One cycle with the given strobes, starting and ending on a falling edge
  task automatic tick(input logic s, input logic u, input logic d, input logic r);
    step = s; shift_up = u; shift_down = d; restart = r;
    @(negedge clk);
    step = 1'b0; shift_up = 1'b0; shift_down = 1'b0; restart = 1'b0;
  endtask

  task automatic do_step();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    $display("step: rpm=%0d gear=%0d speed=%0d pos=%0d lim=%0b fin=%0b",
             rpm, gear, speed, position, limiter, finished);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rpm"}, 64'(rpm), 64'd1000);
    check({tag, "_gear"}, 64'(gear), 64'd1);
    check({tag, "_speed"}, 64'(speed), 64'd46);
    check({tag, "_pos"}, 64'(position), 64'd0);
    check({tag, "_lim"}, 64'(limiter), 64'd0);
    check({tag, "_fin"}, 64'(finished), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    // Idle revving in STAGED
    throttle = 1'b1;
    do_step(); check("rev1_rpm", 64'(rpm), 64'd1400);
    do_step(); check("rev2_rpm", 64'(rpm), 64'd1800);
    do_step(); check("rev3_rpm", 64'(rpm), 64'd2200);
    check("rev3_speed", 64'(speed), 64'd103);
    check("rev3_pos", 64'(position), 64'd0);

    // Rev limiter
    repeat (14) do_step();
    check("lim_pre_rpm", 64'(rpm), 64'd7800);
    do_step(); check("lim_rpm", 64'(rpm), 64'd8000); check("lim_set", 64'(limiter), 64'd1);
    do_step(); check("cut_rpm", 64'(rpm), 64'd7500); check("cut_clr", 64'(limiter), 64'd0);

    // Upshift, rejected and accepted downshifts
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (13) do_step();
    check("up_pre_rpm", 64'(rpm), 64'd6200);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    do_step(); check("up_gear", 64'(gear), 64'd2); check("up_rpm", 64'(rpm), 64'd4000);
    repeat (10) do_step();
    check("dn_pre_rpm", 64'(rpm), 64'd7000);
    throttle = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 1'b0); tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("dn_rej_gear", 64'(gear), 64'd2); check("dn_rej_rpm", 64'(rpm), 64'd6850);
    tick(1'b1, 1'b1, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("up3_gear", 64'(gear), 64'd3); check("up3_rpm", 64'(rpm), 64'd4700);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    do_step(); check("dn_ok_gear", 64'(gear), 64'd2); check("dn_ok_rpm", 64'(rpm), 64'd6550);

    // Both requests pending cancel each other
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    do_step(); check("both_gear", 64'(gear), 64'd2); check("both_rpm", 64'(rpm), 64'd6400);
    do_step(); check("after_gear", 64'(gear), 64'd2); check("after_speed", 64'(speed), 64'd439);

    // Restart clears a pending request
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    do_step(); check("rst_pend_gear", 64'(gear), 64'd1); check("rst_pend_rpm", 64'(rpm), 64'd1000);

    // Launch, then restart together with a step mid-run
    launch = 1'b1; throttle = 1'b1;
    repeat (12) do_step();
    check("run_moved", 64'(position > 0), 64'd1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check_reset_vals("restart_step");

    // Race to the finish with upshifts near the top of each gear
    for (int i = 0; i < 300 && !m_fin; i++) begin
      if (m_rpm >= 7000 && m_gear < 5) tick(1'b0, 1'b1, 1'b0, 1'b0);
      do_step();
    end
    check("finish_reached", 64'(finished), 64'd1);
    check("finish_pos_ge_line", 64'(position >= FIN), 64'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) do_step();
    check("finish_hold", 64'(finished), 64'd1);

    // Asynchronous reset in the middle of a step cycle
    step = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clk);
    step = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("async_rel");

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
